axis_trg_stamper: RTL and testbench

// - Sits directly downstream of the free-running counter stream source. Consumes its
//   {rdy, cntr} words and zero-word trigger markers, and converts each marker into a

---
 rtl/axis_trg_stamper_pkg.sv | 19 +
 rtl/axis_trg_stamper_if.sv | 13 +
 rtl/axis_trg_stamper_fifo.sv | 72 +++++++
 rtl/axis_trg_stamper.sv | 111 +++++++++++
 tb/tb_axis_trg_stamper.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/axis_trg_stamper_pkg.sv
// Shared definitions for the trigger stamper: default widths, the trigger
// marker word and the layout of an emitted record.
package axis_trg_stamper_pkg;
  localparam int DEF_TDATA_W     = 64;
  localparam int DEF_CNTR_W      = 63;
  localparam int DEF_FIFO_ADDR_W = 4;
  localparam int DEF_STAT_W      = 32;

  // The record stall flag sits in the MSB, right above the timestamp.
  localparam int STALL_BIT = DEF_TDATA_W - 1;

  // An all-zero input word marks a trigger.
  localparam logic [DEF_TDATA_W-1:0] MARKER = '0;

  typedef struct packed {
    logic                  stall;
    logic [DEF_CNTR_W-1:0] ts;
  } rec_t;
endpackage

// File: rtl/axis_trg_stamper_if.sv
// AXI-Stream bundle (tdata/tvalid/tready).
//   master : drives tdata, tvalid; samples tready
//   slave  : samples tdata, tvalid; drives tready
interface axis_if #(
  parameter int W = 64
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_trg_stamper_fifo.sv
// axis_trg_fifo: synchronous first-word-fall-through FIFO with a registered
// head output.
//   clk, rst_n (sync, active-low), clr (sync clear)
//   wr_en/din/full : write side; a write when full is only taken with a same-cycle pop
//   rd_en/dout/empty : read side; dout is the head entry whenever !empty
//   level : entries held, 0..2**ADDR_WIDTH
import axis_trg_stamper_pkg::*;

module axis_trg_fifo #(
  parameter int WIDTH      = DEF_TDATA_W,
  parameter int ADDR_WIDTH = DEF_FIFO_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                wr_ok, rd_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = dout_q;

  assign rd_ok = rd_en & ~empty & ~clr;
  assign wr_ok = wr_en & (~full | rd_ok) & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
      // Preload the next head: the incoming word if it lands at the new head
      // (FIFO empty after this cycle's pop), otherwise the stored entry.
      if (wr_ok && (wr_ptr_q == rd_ptr_d)) dout_d = din;
      else                                 dout_d = mem[rd_ptr_d[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
  end
endmodule

// File: rtl/axis_trg_stamper.sv
// axis_trg_stamper: turns zero-word trigger markers in a {rdy, cntr} stream
// into {stall, timestamp} records, buffered in a FIFO and sent on AXI-Stream.
//   aclk, aresetn (sync, active-low), clr (sync clear of everything)
//   s_axis : counter words / markers in, never back-pressured
//   m_axis : records out, tvalid = FIFO not empty
//   trg_count (wraps), lost_count (saturates), fifo_level
import axis_trg_stamper_pkg::*;

module axis_trg_stamper #(
  parameter int AXIS_TDATA_WIDTH = DEF_TDATA_W,
  parameter int CNTR_WIDTH       = DEF_CNTR_W,
  parameter int FIFO_ADDR_WIDTH  = DEF_FIFO_ADDR_W,
  parameter int STAT_WIDTH       = DEF_STAT_W
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     clr,
  axis_if.slave                    s_axis,
  axis_if.master                   m_axis,
  output logic [STAT_WIDTH-1:0]    trg_count,
  output logic [STAT_WIDTH-1:0]    lost_count,
  output logic [FIFO_ADDR_WIDTH:0] fifo_level
);
  logic [CNTR_WIDTH-1:0] pred_q, pred_d;
  logic                  have_cntr_q, have_cntr_d;
  logic                  stall_acc_q, stall_acc_d;
  logic [STAT_WIDTH-1:0] trg_q, trg_d, lost_q, lost_d;

  logic beat, marker, cword, cand, pop, wr_en, lose;
  logic fifo_full, fifo_empty;
  logic [AXIS_TDATA_WIDTH-1:0] rec;

  assign s_axis.tready = 1'b1;

  assign beat   = s_axis.tvalid;
  assign marker = beat && (s_axis.tdata == {AXIS_TDATA_WIDTH{1'b0}});
  assign cword  = beat && !marker;
  assign cand   = marker && have_cntr_q;
  assign pop    = m_axis.tvalid && m_axis.tready;
  // A full FIFO still takes the record when its head leaves this cycle.
  assign wr_en  = cand && (!fifo_full || pop) && !clr;
  // Orphaned marker or FIFO overflow: exactly one loss per marker at most.
  assign lose   = marker && !(cand && (!fifo_full || pop));
  assign rec    = {stall_acc_q, pred_q};

  always_comb begin
    pred_d      = pred_q;
    have_cntr_d = have_cntr_q;
    stall_acc_d = stall_acc_q;
    trg_d       = trg_q;
    lost_d      = lost_q;
    if (clr) begin
      pred_d      = '0;
      have_cntr_d = 1'b0;
      stall_acc_d = 1'b0;
      trg_d       = '0;
      lost_d      = '0;
    end else begin
      if (cword) begin
        pred_d      = s_axis.tdata[CNTR_WIDTH-1:0] + CNTR_WIDTH'(1);
        have_cntr_d = 1'b1;
        if (!s_axis.tdata[CNTR_WIDTH]) stall_acc_d = 1'b1;
      end
      if (marker) begin
        trg_d = trg_q + STAT_WIDTH'(1);
        // Back-to-back markers model a counter advancing once per cycle.
        if (have_cntr_q) begin
          pred_d      = pred_q + CNTR_WIDTH'(1);
          stall_acc_d = 1'b0;
        end
      end
      if (lose && (lost_q != {STAT_WIDTH{1'b1}})) lost_d = lost_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pred_q      <= '0;
      have_cntr_q <= 1'b0;
      stall_acc_q <= 1'b0;
      trg_q       <= '0;
      lost_q      <= '0;
    end else begin
      pred_q      <= pred_d;
      have_cntr_q <= have_cntr_d;
      stall_acc_q <= stall_acc_d;
      trg_q       <= trg_d;
      lost_q      <= lost_d;
    end
  end

  axis_trg_fifo #(
    .WIDTH      (AXIS_TDATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .clr   (clr),
    .wr_en (wr_en),
    .din   (rec),
    .full  (fifo_full),
    .rd_en (pop),
    .dout  (m_axis.tdata),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign trg_count     = trg_q;
  assign lost_count    = lost_q;
endmodule

// File: tb/tb_axis_trg_stamper.sv
module tb_axis_trg_stamper;
  import axis_trg_stamper_pkg::*;

  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        clr;
  logic [31:0] trg_count, lost_count;
  logic [4:0]  fifo_level;

  axis_if #(.W(64)) s_if ();
  axis_if #(.W(64)) m_if ();

  axis_trg_stamper dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .clr        (clr),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .trg_count  (trg_count),
    .lost_count (lost_count),
    .fifo_level (fifo_level)
  );

  always #5 aclk = ~aclk;

  // reference model state
  logic [63:0]   q[$];
  logic [62:0]   m_pred;
  bit            m_have, m_stall;
  int unsigned   m_trg, m_lost;
  int            total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cw(input bit rdy, input logic [62:0] v);
    return {rdy, v};
  endfunction

  task automatic model_clear();
    q.delete();
    m_pred = '0; m_have = 0; m_stall = 0; m_trg = 0; m_lost = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, check on the falling edge.
  task automatic step(input bit v, input logic [63:0] d, input bit rdy,
                      input bit c = 0, input bit rst = 0);
    bit pop, acc;
    rec_t r;
    s_if.tvalid = v; s_if.tdata = d; m_if.tready = rdy; clr = c; aresetn = !rst;
    @(posedge aclk);
    if (rst || c) model_clear();
    else begin
      pop = (q.size() != 0) && rdy;
      acc = m_have && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (v && d == 64'd0) begin
        m_trg++;
        if (acc) begin
          r.stall = m_stall; r.ts = m_pred;
          q.push_back(r);
        end else if (m_lost != 32'hffff_ffff) m_lost++;
        if (m_have) begin m_pred = m_pred + 1; m_stall = 0; end
      end else if (v) begin
        m_pred = d[62:0] + 1; m_have = 1;
        if (!d[63]) m_stall = 1;
      end
    end
    @(negedge aclk);
    chk("tvalid", {63'd0, m_if.tvalid}, {63'd0, q.size() != 0});
    if (q.size() != 0) chk("tdata", m_if.tdata, q[0]);
    chk("level", {59'd0, fifo_level}, 64'(q.size()));
    chk("trg", {32'd0, trg_count}, {32'd0, m_trg});
    chk("lost", {32'd0, lost_count}, {32'd0, m_lost});
  endtask

  task automatic do_reset();
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
  endtask

  initial begin
    s_if.tvalid = 0; s_if.tdata = '0; m_if.tready = 0; clr = 0; aresetn = 0;
    model_clear();
    @(negedge aclk);
    do_reset();
    chk("rst_level", {59'd0, fifo_level}, 64'd0);
    chk("s_tready", {63'd0, s_if.tready}, 64'd1);

    // counter 100..102, marker, counter 104
    step(1, cw(1, 100), 0); step(1, cw(1, 101), 0); step(1, cw(1, 102), 0);
    step(1, MARKER, 0);
    chk("t1_valid", {63'd0, m_if.tvalid}, 64'd1);
    chk("t1_data", m_if.tdata, 64'd103);
    step(1, cw(1, 104), 0);
    chk("t1_level", {59'd0, fifo_level}, 64'd1);
    chk("t1_trg", {32'd0, trg_count}, 64'd1);
    step(0, '0, 1);
    chk("t1_drain", {59'd0, fifo_level}, 64'd0);

    // orphan marker right after reset
    do_reset();
    step(1, MARKER, 1);
    chk("t2_lost", {32'd0, lost_count}, 64'd1);
    chk("t2_valid", {63'd0, m_if.tvalid}, 64'd0);

    // stall accumulation
    do_reset();
    step(1, cw(0, 5), 0); step(1, MARKER, 0); step(1, MARKER, 0);
    chk("t3_rec0", m_if.tdata, 64'h8000_0000_0000_0006);
    step(0, '0, 1);
    chk("t3_rec1", m_if.tdata, 64'h0000_0000_0000_0007);
    step(0, '0, 1);

    // overflow: 17 markers into depth 16, then full + pop + marker
    do_reset();
    step(1, cw(1, 0), 0);
    for (int i = 0; i < 17; i++) step(1, MARKER, 0);
    chk("t4_full", {59'd0, fifo_level}, 64'd16);
    chk("t4_lost", {32'd0, lost_count}, 64'd1);
    step(1, MARKER, 1);
    chk("t4_nolost", {32'd0, lost_count}, 64'd1);
    chk("t4_level", {59'd0, fifo_level}, 64'd16);
    for (int i = 0; i < 16; i++) step(0, '0, 1);
    chk("t4_empty", {59'd0, fifo_level}, 64'd0);

    // pred wrap
    do_reset();
    step(1, cw(1, 63'h7fff_ffff_ffff_ffff), 0); step(1, MARKER, 0); step(1, MARKER, 0);
    chk("t5_ts0", m_if.tdata, 64'd0);
    step(0, '0, 1);
    chk("t5_ts1", m_if.tdata, 64'd1);
    step(0, '0, 1);

    // reset mid-burst, then clr with a marker
    do_reset();
    step(1, cw(1, 10), 0); step(1, MARKER, 0); step(1, MARKER, 0);
    step(1, MARKER, 0, 0, 1);
    chk("t6_rst_lvl", {59'd0, fifo_level}, 64'd0);
    step(1, MARKER, 0);
    chk("t6_orphan", {32'd0, lost_count}, 64'd1);
    step(1, cw(1, 20), 0); step(1, MARKER, 0);
    step(1, MARKER, 0, 1, 0);
    chk("t6_clr_trg", {32'd0, trg_count}, 64'd0);
    chk("t6_clr_lvl", {59'd0, fifo_level}, 64'd0);
    step(1, MARKER, 1);
    chk("t6_orphan2", {32'd0, lost_count}, 64'd1);

    // random traffic
    begin
      bit slow;
      logic [63:0] d;
      slow = 0;
      for (int i = 0; i < 3000; i++) begin
        if (i % 64 == 0) slow = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 2) == 0) d = MARKER;
        else d = {$urandom, $urandom};
        step($urandom_range(0, 9) < 8, d,
             slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
             $urandom_range(0, 299) == 0, $urandom_range(0, 599) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
